// File: rtl/nn_layer_sequencer.sv
// nn_layer_sequencer: control sequencer for one fully-connected NN layer.
// A 5-word descriptor (in_base, w_base, out_base, n_in, n_out) is captured over the
// config bus. The sequencer then walks NUM_PE-wide input chunks for every output neuron.
// Define NN_SEQ_PERF_EN to add the perf_busy / perf_stall cycle counters.
//
// state     | meaning
// IDLE      | waiting for enable
// CONFIG    | capturing descriptor words 0..4
// WAIT_DVAL | waiting for input data valid before starting a chunk
// FETCH     | NUM_PE cycles of weight fetch and multiply
// ADD       | ADD_LAT cycles of adder-tree reduction
// UPDATE    | advance chunk/neuron, emit neuron and layer completion pulses
module nn_layer_sequencer #(
    parameter int DW      = 16,
    parameter int NUM_PE  = 16,
    parameter int ADD_LAT = 4,
    parameter int CNT_W   = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic              bus_wr,
    input  logic [DW-1:0]     bus_data,
    input  logic              dval,
    output logic [DW-1:0]     in_addr,
    output logic [DW-1:0]     weight_addr,
    output logic [DW-1:0]     out_addr,
    output logic              rd_bram,
    output logic              weight_rd,
    output logic              pe_enable,
    output logic [NUM_PE-1:0] lane_mask,
    output logic              acc_clear,
    output logic              add_done,
    output logic              wr_bram,
    output logic              neuron_done,
    output logic              layer_done,
    output logic              busy,
    output logic              cfg_err
`ifdef NN_SEQ_PERF_EN
    ,
    output logic [31:0]       perf_busy,
    output logic [31:0]       perf_stall
`endif
);

    localparam int LG = $clog2(NUM_PE);
    localparam int CW = $clog2((NUM_PE > ADD_LAT ? NUM_PE : ADD_LAT) + 1);

    typedef enum logic [2:0] {IDLE, CONFIG, WAIT_DVAL, FETCH, ADD, UPDATE} state_t;

    state_t           state;
    logic [2:0]       word_idx;
    logic [CW-1:0]    cnt;
    logic [DW-1:0]    in_base;
    logic [DW-1:0]    n_in;
    logic [DW-1:0]    n_out;
    logic [CNT_W-1:0] nchunk;
    logic [CNT_W-1:0] chunk;
    logic [CNT_W-1:0] neuron;
    logic             last_chunk;
    logic             last_neuron;

    assign last_chunk  = (chunk == nchunk - CNT_W'(1));
    assign last_neuron = (DW'(neuron) == n_out - DW'(1));

    // Lane k is live when its global input index chunk*NUM_PE + k is below n_in.
    function automatic logic [NUM_PE-1:0] chunk_mask(input logic [CNT_W-1:0] c,
                                                     input logic [DW-1:0]    n);
        logic [NUM_PE-1:0] m;
        logic [63:0]       base;
        base = 64'(c) * 64'(NUM_PE);
        for (int k = 0; k < NUM_PE; k++) begin
            m[k] = (base + 64'(k)) < 64'(n);
        end
        return m;
    endfunction

    // Main sequencer: state, counters, descriptor and all registered outputs.
    // Status outputs (busy, weight_rd, pe_enable, add_done, wr_bram, neuron_done,
    // layer_done) are set on entry so they line up with the state they describe.
    // This keeps out_addr equal to the finishing neuron while neuron_done is high.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= IDLE;
            word_idx    <= '0;
            cnt         <= '0;
            in_base     <= '0;
            n_in        <= '0;
            n_out       <= '0;
            nchunk      <= '0;
            chunk       <= '0;
            neuron      <= '0;
            in_addr     <= '0;
            weight_addr <= '0;
            out_addr    <= '0;
            rd_bram     <= 1'b0;
            weight_rd   <= 1'b0;
            pe_enable   <= 1'b0;
            lane_mask   <= '1;
            acc_clear   <= 1'b0;
            add_done    <= 1'b0;
            wr_bram     <= 1'b0;
            neuron_done <= 1'b0;
            layer_done  <= 1'b0;
            busy        <= 1'b0;
            cfg_err     <= 1'b0;
        end else begin
            rd_bram     <= 1'b0;
            acc_clear   <= 1'b0;
            wr_bram     <= 1'b0;
            neuron_done <= 1'b0;
            layer_done  <= 1'b0;
            cfg_err     <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (enable) begin
                        state    <= CONFIG;
                        word_idx <= '0;
                        busy     <= 1'b1;
                    end
                end
                CONFIG: begin
                    if (bus_wr) begin
                        word_idx <= word_idx + 3'd1;
                        unique case (word_idx)
                            3'd0: begin
                                in_base <= bus_data;
                                in_addr <= bus_data;
                            end
                            3'd1: weight_addr <= bus_data;
                            3'd2: out_addr    <= bus_data;
                            3'd3: n_in        <= bus_data;
                            default: begin
                                n_out <= bus_data;
                                if (n_in == '0 || bus_data == '0) begin
                                    cfg_err <= 1'b1;
                                    busy    <= 1'b0;
                                    state   <= IDLE;
                                end else begin
                                    // Widened by one bit so the round-up cannot overflow.
                                    nchunk    <= CNT_W'(({1'b0, n_in} + (DW+1)'(NUM_PE - 1)) >> LG);
                                    chunk     <= '0;
                                    neuron    <= '0;
                                    lane_mask <= chunk_mask('0, n_in);
                                    state     <= WAIT_DVAL;
                                end
                            end
                        endcase
                    end
                end
                WAIT_DVAL: begin
                    if (dval) begin
                        rd_bram   <= 1'b1;
                        acc_clear <= (chunk == '0);
                        weight_rd <= 1'b1;
                        pe_enable <= 1'b1;
                        cnt       <= CW'(NUM_PE - 1);
                        state     <= FETCH;
                    end
                end
                FETCH: begin
                    weight_addr <= weight_addr + DW'(1);
                    if (cnt == '0) begin
                        in_addr   <= in_addr + DW'(NUM_PE);
                        weight_rd <= 1'b0;
                        cnt       <= CW'(ADD_LAT - 1);
                        add_done  <= (ADD_LAT == 1);
                        state     <= ADD;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                ADD: begin
                    if (cnt == '0) begin
                        add_done  <= 1'b0;
                        pe_enable <= 1'b0;
                        state     <= UPDATE;
                        if (last_chunk) begin
                            wr_bram     <= 1'b1;
                            neuron_done <= 1'b1;
                            layer_done  <= last_neuron;
                        end
                    end else begin
                        cnt      <= cnt - CW'(1);
                        add_done <= (cnt == CW'(1));
                    end
                end
                UPDATE: begin
                    if (!last_chunk) begin
                        chunk     <= chunk + CNT_W'(1);
                        lane_mask <= chunk_mask(chunk + CNT_W'(1), n_in);
                        state     <= WAIT_DVAL;
                    end else begin
                        chunk   <= '0;
                        in_addr <= in_base;
                        if (last_neuron) begin
                            neuron <= '0;
                            busy   <= 1'b0;
                            state  <= IDLE;
                        end else begin
                            out_addr  <= out_addr + DW'(1);
                            neuron    <= neuron + CNT_W'(1);
                            lane_mask <= chunk_mask('0, n_in);
                            state     <= WAIT_DVAL;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef NN_SEQ_PERF_EN
    // Saturating busy/stall cycle counters; cleared when a new layer leaves IDLE.
    always_ff @(posedge clk) begin
        if (!rst) begin
            perf_busy  <= '0;
            perf_stall <= '0;
        end else if (state == IDLE) begin
            if (enable) begin
                perf_busy  <= '0;
                perf_stall <= '0;
            end
        end else begin
            if (perf_busy != '1) perf_busy <= perf_busy + 32'd1;
            if (state == WAIT_DVAL && !dval && perf_stall != '1) perf_stall <= perf_stall + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_nn_layer_sequencer.sv
// Self-checking bench for nn_layer_sequencer (default parameters).
// Define NN_SEQ_PERF_EN to also exercise the perf counters.
module tb_nn_layer_sequencer;

    localparam int DW = 16, NUM_PE = 16, ADD_LAT = 4, CNT_W = 10;

    logic clk = 1'b0, rst = 1'b0, enable = 1'b0, bus_wr = 1'b0, dval = 1'b0;
    logic [DW-1:0] bus_data = '0;
    logic [DW-1:0] in_addr, weight_addr, out_addr;
    logic rd_bram, weight_rd, pe_enable, acc_clear, add_done, wr_bram;
    logic neuron_done, layer_done, busy, cfg_err;
    logic [NUM_PE-1:0] lane_mask;
`ifdef NN_SEQ_PERF_EN
    logic [31:0] perf_busy, perf_stall;
`endif

    int checks = 0, errors = 0;

    always #5 clk = ~clk;

    nn_layer_sequencer #(.DW(DW), .NUM_PE(NUM_PE), .ADD_LAT(ADD_LAT), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .enable(enable), .bus_wr(bus_wr), .bus_data(bus_data), .dval(dval),
        .in_addr(in_addr), .weight_addr(weight_addr), .out_addr(out_addr),
        .rd_bram(rd_bram), .weight_rd(weight_rd), .pe_enable(pe_enable), .lane_mask(lane_mask),
        .acc_clear(acc_clear), .add_done(add_done), .wr_bram(wr_bram), .neuron_done(neuron_done),
        .layer_done(layer_done), .busy(busy), .cfg_err(cfg_err)
`ifdef NN_SEQ_PERF_EN
        , .perf_busy(perf_busy), .perf_stall(perf_stall)
`endif
    );

    wire [3*DW+10-1:0] all_out = {in_addr, weight_addr, out_addr, rd_bram, weight_rd, pe_enable,
                                  acc_clear, add_done, wr_bram, neuron_done, layer_done, busy, cfg_err};

    // Scoreboard: expected per-chunk and per-neuron values, and what the DUT produced.
    logic [DW-1:0]     exp_in[$], exp_w[$], exp_out[$];
    logic [NUM_PE-1:0] exp_mask[$];
    logic [DW-1:0]     act_in[$], act_w[$], act_out[$];
    logic [NUM_PE-1:0] act_mask[$];
    int n_acc, n_wrd, n_pe, n_layer, n_cfg, n_wr_mis, last_add_cyc, busy_fall_cyc;
    int cyc = 0;
    logic prev_busy = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: record DUT events away from the active edge.
    always @(negedge clk) begin
        if (rd_bram) begin
            act_in.push_back(in_addr);
            act_w.push_back(weight_addr);
            act_mask.push_back(lane_mask);
        end
        if (neuron_done) act_out.push_back(out_addr);
        if (neuron_done !== wr_bram) n_wr_mis++;
        if (acc_clear)  n_acc++;
        if (weight_rd)  n_wrd++;
        if (pe_enable)  n_pe++;
        if (layer_done) n_layer++;
        if (cfg_err)    n_cfg++;
        if (add_done)   last_add_cyc = cyc;
        if (prev_busy && !busy) busy_fall_cyc = cyc;
        prev_busy = busy;
    end

    task automatic mon_clear();
        exp_in.delete(); exp_w.delete(); exp_out.delete(); exp_mask.delete();
        act_in.delete(); act_w.delete(); act_out.delete(); act_mask.delete();
        n_acc = 0; n_wrd = 0; n_pe = 0; n_layer = 0; n_cfg = 0; n_wr_mis = 0;
        last_add_cyc = 0; busy_fall_cyc = 0;
    endtask

    // Reference model: expected chunk addresses, masks and neuron output addresses.
    task automatic expect_layer(input logic [DW-1:0] ib, input logic [DW-1:0] wb,
                                input logic [DW-1:0] ob, input logic [DW-1:0] ni,
                                input logic [DW-1:0] no);
        int nck, rem;
        logic [NUM_PE-1:0] m;
        nck = (int'(ni) + NUM_PE - 1) / NUM_PE;
        for (int n = 0; n < int'(no); n++) begin
            for (int c = 0; c < nck; c++) begin
                exp_in.push_back(ib + DW'(c * NUM_PE));
                exp_w.push_back(wb + DW'((n * nck + c) * NUM_PE));
                rem = int'(ni) - c * NUM_PE;
                if (rem >= NUM_PE) m = '1;
                else m = NUM_PE'((1 << rem) - 1);
                exp_mask.push_back(m);
            end
            exp_out.push_back(ob + DW'(n));
        end
    endtask

    task automatic send_desc(input logic [DW-1:0] w0, input logic [DW-1:0] w1,
                             input logic [DW-1:0] w2, input logic [DW-1:0] w3,
                             input logic [DW-1:0] w4, input int gap);
        logic [DW-1:0] words[5];
        words = '{w0, w1, w2, w3, w4};
        @(negedge clk); enable = 1'b1;
        @(negedge clk); enable = 1'b0;
        for (int i = 0; i < 5; i++) begin
            repeat (gap) @(negedge clk);
            bus_wr = 1'b1; bus_data = words[i];
            @(negedge clk);
            bus_wr = 1'b0;
        end
    endtask

    task automatic wait_idle(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (busy === 1'b0) begin ok = 1'b1; break; end
        end
        repeat (2) @(negedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0; enable = 1'b0; bus_wr = 1'b0; dval = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (all_out !== '0 || lane_mask !== '1) begin
            errors++; $display("FAIL reset_outputs: got outs=%h mask=%h want 0 / ffff", all_out, lane_mask);
        end
        rst = 1'b1;
        bus_wr = 1'b1; bus_data = 16'hBEEF;
        repeat (3) @(negedge clk);
        bus_wr = 1'b0;
        checks++;
        if (busy !== 1'b0 || all_out !== '0) begin
            errors++; $display("FAIL idle_bus_wr: got busy=%b outs=%h want 0", busy, all_out);
        end
    endtask

    task automatic test_basic();
        bit ok;
        mon_clear(); dval = 1'b1;
        expect_layer(16'h0100, 16'h2000, 16'h0400, 16'd32, 16'd2);
        send_desc(16'h0100, 16'h2000, 16'h0400, 16'd32, 16'd2, 0);
        wait_idle(500, ok);
        dval = 1'b0;
        checks++; if (!ok) begin errors++; $display("FAIL basic_timeout: busy=%b want 0", busy); end
        checks++; if (act_in.size() !== 4) begin errors++; $display("FAIL basic_rd_bram: got %0d want 4", act_in.size()); end
        checks++; if (n_wrd !== 64) begin errors++; $display("FAIL basic_weight_rd: got %0d want 64", n_wrd); end
        checks++; if (n_pe !== 80) begin errors++; $display("FAIL basic_pe_enable: got %0d want 80", n_pe); end
        checks++; if (n_acc !== 2) begin errors++; $display("FAIL basic_acc_clear: got %0d want 2", n_acc); end
        checks++; if (n_layer !== 1) begin errors++; $display("FAIL basic_layer_done: got %0d want 1", n_layer); end
        checks++; if (n_wr_mis !== 0) begin errors++; $display("FAIL basic_wr_vs_nd: got %0d want 0", n_wr_mis); end
        checks++;
        if (busy_fall_cyc - last_add_cyc !== 2) begin
            errors++; $display("FAIL basic_busy_fall: got %0d want 2", busy_fall_cyc - last_add_cyc);
        end
        checks++;
        if (act_out.size() !== exp_out.size()) begin
            errors++; $display("FAIL basic_nd_count: got %0d want %0d", act_out.size(), exp_out.size());
        end
        while (exp_in.size() > 0 && act_in.size() > 0) begin
            checks++;
            if ({act_in[0], act_w[0], act_mask[0]} !== {exp_in[0], exp_w[0], exp_mask[0]}) begin
                errors++; $display("FAIL basic_chunk: got in=%h w=%h mask=%h want in=%h w=%h mask=%h",
                                   act_in[0], act_w[0], act_mask[0], exp_in[0], exp_w[0], exp_mask[0]);
            end
            void'(act_in.pop_front()); void'(act_w.pop_front()); void'(act_mask.pop_front());
            void'(exp_in.pop_front()); void'(exp_w.pop_front()); void'(exp_mask.pop_front());
        end
        while (exp_out.size() > 0 && act_out.size() > 0) begin
            checks++;
            if (act_out[0] !== exp_out[0]) begin
                errors++; $display("FAIL basic_out_addr: got %h want %h", act_out[0], exp_out[0]);
            end
            void'(act_out.pop_front()); void'(exp_out.pop_front());
        end
    endtask

    task automatic test_partial();
        bit ok;
        mon_clear(); dval = 1'b1;
        expect_layer(16'h0100, 16'h3000, 16'h0500, 16'd20, 16'd1);
        send_desc(16'h0100, 16'h3000, 16'h0500, 16'd20, 16'd1, 0);
        wait_idle(500, ok);
        dval = 1'b0;
        checks++; if (!ok) begin errors++; $display("FAIL partial_timeout: busy=%b want 0", busy); end
        checks++; if (act_in.size() !== 2) begin errors++; $display("FAIL partial_rd_bram: got %0d want 2", act_in.size()); end
        checks++; if (n_acc !== 1) begin errors++; $display("FAIL partial_acc_clear: got %0d want 1", n_acc); end
        checks++; if (n_layer !== 1) begin errors++; $display("FAIL partial_layer_done: got %0d want 1", n_layer); end
        while (exp_in.size() > 0 && act_in.size() > 0) begin
            checks++;
            if ({act_in[0], act_w[0], act_mask[0]} !== {exp_in[0], exp_w[0], exp_mask[0]}) begin
                errors++; $display("FAIL partial_chunk: got in=%h w=%h mask=%h want in=%h w=%h mask=%h",
                                   act_in[0], act_w[0], act_mask[0], exp_in[0], exp_w[0], exp_mask[0]);
            end
            void'(act_in.pop_front()); void'(act_w.pop_front()); void'(act_mask.pop_front());
            void'(exp_in.pop_front()); void'(exp_w.pop_front()); void'(exp_mask.pop_front());
        end
        checks++;
        if (act_out.size() !== 1 || exp_out.size() !== 1 || act_out[0] !== exp_out[0]) begin
            errors++; $display("FAIL partial_out_addr: got n=%0d want 1 at %h", act_out.size(), exp_out[0]);
        end
    endtask

    task automatic test_bad_desc();
        bit ok;
        mon_clear(); dval = 1'b1;
        send_desc(16'h0100, 16'h2000, 16'h0400, 16'd0, 16'd3, 0);
        wait_idle(50, ok);
        checks++; if (!ok || busy !== 1'b0) begin errors++; $display("FAIL bad_nin_busy: got busy=%b want 0", busy); end
        checks++; if (n_cfg !== 1) begin errors++; $display("FAIL bad_nin_cfg_err: got %0d want 1", n_cfg); end
        checks++; if (act_in.size() !== 0) begin errors++; $display("FAIL bad_nin_rd_bram: got %0d want 0", act_in.size()); end
        mon_clear();
        send_desc(16'h0100, 16'h2000, 16'h0400, 16'd16, 16'd0, 0);
        wait_idle(50, ok);
        dval = 1'b0;
        checks++; if (!ok || busy !== 1'b0) begin errors++; $display("FAIL bad_nout_busy: got busy=%b want 0", busy); end
        checks++; if (n_cfg !== 1) begin errors++; $display("FAIL bad_nout_cfg_err: got %0d want 1", n_cfg); end
        checks++; if (act_in.size() !== 0) begin errors++; $display("FAIL bad_nout_rd_bram: got %0d want 0", act_in.size()); end
    endtask

    task automatic test_stall();
        bit ok;
        mon_clear(); dval = 1'b0;
        expect_layer(16'h0700, 16'h5000, 16'h0800, 16'd16, 16'd1);
        send_desc(16'h0700, 16'h5000, 16'h0800, 16'd16, 16'd1, 0);
        repeat (7) @(negedge clk);
        #1;
        checks++;
        if ({in_addr, weight_addr, out_addr, lane_mask} !== {16'h0700, 16'h5000, 16'h0800, 16'hFFFF} ||
            {rd_bram, weight_rd, pe_enable, busy} !== 4'b0001 || act_in.size() !== 0) begin
            errors++; $display("FAIL stall_hold: got in=%h w=%h out=%h mask=%h rd/wr/pe/busy=%b%b%b%b want 0700 5000 0800 ffff 0001",
                               in_addr, weight_addr, out_addr, lane_mask, rd_bram, weight_rd, pe_enable, busy);
        end
`ifdef NN_SEQ_PERF_EN
        checks++; if (perf_stall !== 32'd7) begin errors++; $display("FAIL stall_perf_stall: got %0d want 7", perf_stall); end
        checks++; if (perf_busy !== 32'd12) begin errors++; $display("FAIL stall_perf_busy: got %0d want 12", perf_busy); end
`endif
        dval = 1'b1;
        wait_idle(200, ok);
        dval = 1'b0;
        checks++; if (!ok || n_layer !== 1) begin errors++; $display("FAIL stall_layer_done: got %0d want 1", n_layer); end
        checks++;
        if (act_in.size() !== 1 || act_in[0] !== exp_in[0] || act_w[0] !== exp_w[0] ||
            act_out.size() !== 1 || act_out[0] !== exp_out[0]) begin
            errors++; $display("FAIL stall_scoreboard: got rd=%0d nd=%0d want 1 chunk at %h, out %h",
                               act_in.size(), act_out.size(), exp_in[0], exp_out[0]);
        end
`ifdef NN_SEQ_PERF_EN
        checks++; if (perf_stall !== 32'd7) begin errors++; $display("FAIL stall_perf_hold: got %0d want 7", perf_stall); end
        checks++; if (perf_busy !== 32'd34) begin errors++; $display("FAIL stall_perf_total: got %0d want 34", perf_busy); end
`endif
    endtask

    task automatic test_reset_mid();
        bit ok, seen;
        mon_clear(); dval = 1'b1;
        send_desc(16'h0100, 16'h2000, 16'h0400, 16'd16, 16'd2, 0);
        seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin @(negedge clk); seen = neuron_done; end
        for (int i = 0; i < 100 && seen; i++) begin
            @(negedge clk);
            if (pe_enable && !weight_rd) break;
            if (i == 99) seen = 1'b0;
        end
        checks++; if (!seen) begin errors++; $display("FAIL rstmid_reach_add: got timeout want ADD of neuron 1"); end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (all_out !== '0 || lane_mask !== '1) begin
            errors++; $display("FAIL rstmid_outputs: got outs=%h mask=%h want 0 / ffff", all_out, lane_mask);
        end
        rst = 1'b1;
        repeat (30) @(negedge clk);
        #1;
        checks++;
        if (n_layer !== 0 || busy !== 1'b0) begin
            errors++; $display("FAIL rstmid_no_done: got layer_done=%0d busy=%b want 0 0", n_layer, busy);
        end
        mon_clear();
        expect_layer(16'h0A00, 16'h6000, 16'h0C00, 16'd16, 16'd1);
        send_desc(16'h0A00, 16'h6000, 16'h0C00, 16'd16, 16'd1, 0);
        wait_idle(200, ok);
        dval = 1'b0;
        checks++; if (!ok || n_layer !== 1) begin errors++; $display("FAIL rstmid_rerun_done: got %0d want 1", n_layer); end
        checks++;
        if (act_in.size() !== 1 || act_in[0] !== exp_in[0] || act_w[0] !== exp_w[0] || act_mask[0] !== exp_mask[0] ||
            act_out.size() !== 1 || act_out[0] !== exp_out[0]) begin
            errors++; $display("FAIL rstmid_rerun_scoreboard: got rd=%0d nd=%0d want 1 chunk at %h, out %h",
                               act_in.size(), act_out.size(), exp_in[0], exp_out[0]);
        end
    endtask

    task automatic test_config_gaps();
        bit ok, seen;
        mon_clear(); dval = 1'b1;
        expect_layer(16'h0200, 16'h4000, 16'h0600, 16'd32, 16'd2);
        send_desc(16'h0200, 16'h4000, 16'h0600, 16'd32, 16'd2, 3);
        seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin @(negedge clk); seen = weight_rd; end
        checks++; if (!seen) begin errors++; $display("FAIL gaps_reach_fetch: got timeout want FETCH"); end
        bus_wr = 1'b1; bus_data = 16'hDEAD; enable = 1'b1;
        repeat (4) @(negedge clk);
        bus_wr = 1'b0; enable = 1'b0;
        wait_idle(500, ok);
        dval = 1'b0;
        checks++; if (!ok || n_layer !== 1) begin errors++; $display("FAIL gaps_layer_done: got %0d want 1", n_layer); end
        checks++;
        if (act_in.size() !== exp_in.size() || act_out.size() !== exp_out.size()) begin
            errors++; $display("FAIL gaps_counts: got rd=%0d nd=%0d want %0d %0d",
                               act_in.size(), act_out.size(), exp_in.size(), exp_out.size());
        end
        while (exp_in.size() > 0 && act_in.size() > 0) begin
            checks++;
            if ({act_in[0], act_w[0], act_mask[0]} !== {exp_in[0], exp_w[0], exp_mask[0]}) begin
                errors++; $display("FAIL gaps_chunk: got in=%h w=%h mask=%h want in=%h w=%h mask=%h",
                                   act_in[0], act_w[0], act_mask[0], exp_in[0], exp_w[0], exp_mask[0]);
            end
            void'(act_in.pop_front()); void'(act_w.pop_front()); void'(act_mask.pop_front());
            void'(exp_in.pop_front()); void'(exp_w.pop_front()); void'(exp_mask.pop_front());
        end
        while (exp_out.size() > 0 && act_out.size() > 0) begin
            checks++;
            if (act_out[0] !== exp_out[0]) begin
                errors++; $display("FAIL gaps_out_addr: got %h want %h", act_out[0], exp_out[0]);
            end
            void'(act_out.pop_front()); void'(exp_out.pop_front());
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_partial();
        test_bad_desc();
        test_stall();
        test_reset_mid();
        test_config_gaps();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion within 200000 time units want completion");
        $fatal(1);
    end

endmodule
